// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: bus widths, RAM depth, loader state encoding and opcode values.
// Used by the program-RAM loader and any other SAP-1 block that needs them.
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;
  localparam int SAP_DEPTH  = 2 ** SAP_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

  // SAP-1 instruction opcodes (upper nibble of a program word)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sap_ram_loader.sv
// Streams bytes into consecutive SAP-1 program-RAM words, holding the CPU off via prog_mode.
// Define SAP_LOADER_VERIFY_EN to read back and compare every written word (sticky err).
module sap_ram_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_ce,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              prog_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output loader_state_e     dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              prog_q;
  logic              done_q;
  logic              abort_now;
  logic              last_byte;

  assign abort_now = abort && (state_q != ST_IDLE);
  assign last_byte = (cnt_q == ONE_C);

  // Stream handshake: a byte transfers on a posedge where s_valid && s_ready are both high.
  // s_ready is high only in RECV and drops combinationally under abort so no byte is lost.
  assign s_ready   = (state_q == ST_RECV) && !abort;
  assign ram_we    = (state_q == ST_WRITE) && !abort;
  assign ram_add   = addr_q;
  assign ram_din   = data_q;
  assign prog_mode = prog_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef SAP_LOADER_VERIFY_EN
  logic err_q;
  assign ram_ce = (state_q == ST_CHECK) && !abort;
  assign err    = err_q;
`else
  logic unused_dout;
  assign unused_dout = ^ram_dout;
  assign ram_ce      = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      prog_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SAP_LOADER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else if (abort_now) begin
      state_q <= ST_IDLE;
      prog_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            addr_q <= start_addr;
            cnt_q  <= (load_len > DEPTH_C) ? DEPTH_C : load_len;
            prog_q <= 1'b1;
`ifdef SAP_LOADER_VERIFY_EN
            err_q  <= 1'b0;
`endif
            if (load_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (s_valid) begin
            data_q  <= s_data;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
`ifdef SAP_LOADER_VERIFY_EN
          state_q <= ST_CHECK;
`else
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
          if (last_byte) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RECV;
          end
`endif
        end
`ifdef SAP_LOADER_VERIFY_EN
        ST_CHECK: begin
          if (ram_dout != data_q) err_q <= 1'b1;
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
          if (last_byte) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RECV;
          end
        end
`endif
        ST_DONE: begin
          done_q  <= 1'b0;
          prog_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_ram_loader.sv
// Directed bench for sap_ram_loader: RAM model, write-log scoreboard, done/ce monitors.
// Build with SAP_LOADER_VERIFY_EN defined to also exercise the read-back compare path.
module tb_sap_ram_loader;
  import sap_pkg::*;

`ifdef SAP_LOADER_VERIFY_EN
  localparam int DONE_LAT = 2;
`else
  localparam int DONE_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [3:0]  start_addr;
  logic [4:0]  load_len;
  logic        abort;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        ram_we;
  logic [3:0]  ram_add;
  logic [7:0]  ram_din;
  logic        ram_ce;
  logic [7:0]  ram_dout;
  logic        prog_mode;
  logic        busy;
  logic        done;
  logic        err;
  loader_state_e dbg_state;

  sap_ram_loader dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .start_addr (start_addr),
    .load_len   (load_len),
    .abort      (abort),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .ram_we     (ram_we),
    .ram_add    (ram_add),
    .ram_din    (ram_din),
    .ram_ce     (ram_ce),
    .ram_dout   (ram_dout),
    .prog_mode  (prog_mode),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic       stuck0;

  initial for (int i = 0; i < 16; i++) mem[i] <= 8'h00;

  always @(posedge clk) if (ram_we) mem[ram_add] <= stuck0 ? (ram_din & 8'hFE) : ram_din;
  assign ram_dout = mem[ram_add];

  // monitors, sampled on the falling edge
  logic [11:0] wr_q [$];
  logic [11:0] exp_q [$];
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ce_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (ram_we) begin
      wr_q.push_back({ram_add, ram_din});
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ram_ce) ce_cnt++;
  end

  // checking
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    while (wr_q.size() > 0 && exp_q.size() > 0) check({tag, "_wr"}, wr_q.pop_front(), exp_q.pop_front());
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, {s_ready, ram_we, ram_ce, prog_mode, busy, done, err}, 7'b0);
    check({tag, "_add"}, ram_add, 4'h0);
    check({tag, "_din"}, ram_din, 8'h00);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // drivers: entered and left at posedge+1
  task automatic do_start(input logic [3:0] a, input logic [4:0] len);
    start_addr = a;
    load_len   = len;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 50);
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, done_cnt - base, 1);
    check({tag, "_prog_in_done"}, prog_mode, 1'b1);
    @(posedge clk); #1;
    check({tag, "_after_done"}, {prog_mode, busy, done}, 3'b000);
  endtask

  initial begin
    int base;
    clr_n = 1'b0; start = 1'b0; start_addr = '0; load_len = '0;
    abort = 1'b0; s_data = '0; s_valid = 1'b0; stuck0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    clr_n = 1'b1;
    @(posedge clk); #1;

    // 1: five bytes back-to-back from address 0
    do_start(4'd0, 5'd5);
    check("t1_busy_prog", {busy, prog_mode}, 2'b11);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back({4'd0, 8'h0F}); exp_q.push_back({4'd1, 8'h1E});
    exp_q.push_back({4'd2, 8'h2D}); exp_q.push_back({4'd3, 8'hE0});
    exp_q.push_back({4'd4, 8'hF0});
    send_byte(8'h0F); send_byte(8'h1E); send_byte(8'h2D); send_byte(8'hE0); send_byte(8'hF0);
    wait_done("t1");
    check("t1_done_lat", done_cyc - last_we_cyc, DONE_LAT);
    check_writes("t1");

    // 2: address wrap 14,15,0,1
    base = done_cnt;
    do_start(4'd14, 5'd4);
    exp_q.push_back({4'd14, 8'h01}); exp_q.push_back({4'd15, 8'h02});
    exp_q.push_back({4'd0, 8'h03});  exp_q.push_back({4'd1, 8'h04});
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    wait_done("t2");
    repeat (5) @(posedge clk);
    #1;
    check("t2_done_once", done_cnt - base, 1);
    check_writes("t2");

    // 3: three idle cycles between bytes, s_ready stays up
    do_start(4'd5, 5'd3);
    exp_q.push_back({4'd5, 8'hA1}); exp_q.push_back({4'd6, 8'hB2}); exp_q.push_back({4'd7, 8'hC3});
    send_byte(8'hA1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
`ifdef SAP_LOADER_VERIFY_EN
      @(posedge clk); #1;
`endif
      repeat (3) begin
        @(negedge clk);
        check("t3_gap_ready", s_ready, 1'b1);
      end
      @(posedge clk); #1;
      send_byte(k == 0 ? 8'hB2 : 8'hC3);
    end
    wait_done("t3");
    check_writes("t3");

    // 4: abort while the 2nd byte is being written
    base = done_cnt;
    do_start(4'd8, 5'd6);
    exp_q.push_back({4'd8, 8'h11});
    send_byte(8'h11);
    send_byte(8'h22);
    abort = 1'b1;
    @(negedge clk);
    check("t4_we_blocked", ram_we, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t4_after_abort", {busy, prog_mode}, 2'b00);
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_done", done_cnt - base, 0);
    check_writes("t4");

    // 5: zero length, then start while busy is ignored
    do_start(4'd3, 5'd0);
    @(negedge clk);
    check("t5_len0_done", {done, prog_mode, ram_we}, 3'b110);
    @(posedge clk); #1;
    check("t5_len0_idle", {busy, prog_mode, done}, 3'b000);
    check_writes("t5a");
    base = done_cnt;
    do_start(4'd0, 5'd2);
    exp_q.push_back({4'd0, 8'h77}); exp_q.push_back({4'd1, 8'h88});
    do_start(4'd10, 5'd5);
    send_byte(8'h77); send_byte(8'h88);
    wait_done("t5b");
    check("t5_done_once", done_cnt - base, 1);
    check_writes("t5b");

    // length above DEPTH clamps to 16 writes
    do_start(4'd0, 5'd20);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({4'(i), 8'h40 + 8'(i)});
      send_byte(8'h40 + 8'(i));
    end
    wait_done("clamp");
    check_writes("clamp");

`ifdef SAP_LOADER_VERIFY_EN
    // 6: stuck-at-0 bit0 makes read-back of 0x05 mismatch
    base = ce_cnt;
    stuck0 = 1'b1;
    do_start(4'd2, 5'd1);
    exp_q.push_back({4'd2, 8'h05});
    send_byte(8'h05);
    wait_done("t6");
    check("t6_err", err, 1'b1);
    check("t6_ce_cycles", ce_cnt - base, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t6_err_sticky", err, 1'b1);
    stuck0 = 1'b0;
    do_start(4'd3, 5'd1);
    check("t6_err_cleared", err, 1'b0);
    exp_q.push_back({4'd3, 8'h06});
    send_byte(8'h06);
    wait_done("t6b");
    check("t6b_err", err, 1'b0);
    check_writes("t6");
`endif

    // reset in the middle of a load
    do_start(4'd2, 5'd4);
    exp_q.push_back({4'd2, 8'h5A});
    send_byte(8'h5A);
    clr_n = 1'b0;
    @(posedge clk); #1;
    check_quiet("midreset");
    clr_n = 1'b1;
    @(posedge clk); #1;
    check_writes("midreset");

`ifndef SAP_LOADER_VERIFY_EN
    check("no_ce_ever", ce_cnt, 0);
    check("err_tied", err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
